// File: rtl/alu_dec_pkg.sv
// Shared encodings for the RISC-V ALU control decoder: ALUOp, funct3 and ALUControl codes.
package alu_dec_pkg;

    localparam int unsigned ALU_CTRL_W = 3;
    localparam int unsigned ALU_OP_W   = 2;
    localparam int unsigned F3_W       = 3;
    localparam int unsigned CNT_W      = 8;

    // ALUOp from the main decoder; both 1x encodings mean arithmetic/logic
    localparam logic [ALU_OP_W-1:0] ALUOP_MEM    = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALUOP_BR     = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALUOP_ARITH1 = 2'b11;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 3'b110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 3'b111;

    localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
    localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
    localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
    localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
    localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
    localparam logic [F3_W-1:0] F3_SR   = 3'b101;
    localparam logic [F3_W-1:0] F3_OR   = 3'b110;
    localparam logic [F3_W-1:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_dec_comb.sv
// Pure combinational ALU control decode; anything unsupported or unknown reports illegal with ADD.
module alu_dec_comb
    import alu_dec_pkg::*;
(
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic [F3_W-1:0]       funct3,
    input  logic                  funct7b5,
    input  logic                  opb5,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_c,
    output logic                  illegal_c
);

    always_comb begin
        alu_ctrl_c = ALU_ADD;
        illegal_c  = 1'b0;
        case (alu_op)
            ALUOP_MEM: alu_ctrl_c = ALU_ADD;
            ALUOP_BR:  alu_ctrl_c = ALU_SUB;
            ALUOP_ARITH, ALUOP_ARITH1: begin
                case (funct3)
                    F3_ADD: begin
                        // Only R-type with bit 30 set is sub; unknown bits fall to illegal
                        case ({opb5, funct7b5})
                            2'b11:               alu_ctrl_c = ALU_SUB;
                            2'b00, 2'b01, 2'b10: alu_ctrl_c = ALU_ADD;
                            default:             illegal_c  = 1'b1;
                        endcase
                    end
                    F3_SLT: alu_ctrl_c = ALU_SLT;
                    F3_OR:  alu_ctrl_c = ALU_OR;
                    F3_AND: alu_ctrl_c = ALU_AND;
                    F3_XOR: alu_ctrl_c = ALU_XOR;
                    F3_SLL: alu_ctrl_c = ALU_SLL;
                    F3_SR: begin
                        // sra/srai have no ALU code in this core
                        case (funct7b5)
                            1'b0:    alu_ctrl_c = ALU_SRL;
                            default: illegal_c  = 1'b1;
                        endcase
                    end
                    F3_SLTU: illegal_c = 1'b1;
                    default: illegal_c = 1'b1;
                endcase
            end
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// ALU control decoder with optional output register stage (OUT_REG).
// Optional illegal-decode counter and sticky flag enabled by macro ALU_DEC_ILLEGAL_CNT_EN.
module alu_ctrl_decoder
    import alu_dec_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter bit          OUT_REG   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 opb5,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic [1:0]           ALUOp,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 out_valid,
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    output logic [7:0]           illegal_cnt,
    output logic                 illegal_sticky,
`endif
    output logic                 illegal
);

    logic [ALU_CTRL_W-1:0] dec_ctrl_c;
    logic                  dec_illegal_c;

    alu_dec_comb u_comb (
        .alu_op     (ALUOp),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .opb5       (opb5),
        .alu_ctrl_c (dec_ctrl_c),
        .illegal_c  (dec_illegal_c)
    );

    if (OUT_REG) begin : g_reg
        logic [ALU_CTRL_W-1:0] alu_ctrl_d, alu_ctrl_q;
        logic                  illegal_d, illegal_q;
        logic                  out_valid_d, out_valid_q;

        // Decoded fields load only on valid cycles; otherwise the last decode is held
        always_comb begin
            alu_ctrl_d  = alu_ctrl_q;
            illegal_d   = illegal_q;
            out_valid_d = in_valid;
            if (in_valid) begin
                alu_ctrl_d = dec_ctrl_c;
                illegal_d  = dec_illegal_c;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                alu_ctrl_q  <= ALU_ADD;
                illegal_q   <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                alu_ctrl_q  <= alu_ctrl_d;
                illegal_q   <= illegal_d;
                out_valid_q <= out_valid_d;
            end
        end

        assign ALUControl = alu_ctrl_q;
        assign illegal    = illegal_q;
        assign out_valid  = out_valid_q;
    end else begin : g_comb
        assign ALUControl = dec_ctrl_c;
        assign illegal    = dec_illegal_c;
        assign out_valid  = in_valid;
    end

`ifdef ALU_DEC_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             sticky_d, sticky_q;

    // Saturating count of accepted illegal decodes, plus a set-until-reset flag
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (in_valid && dec_illegal_c) begin
            sticky_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign illegal_cnt    = cnt_q;
    assign illegal_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Table-driven bench for alu_ctrl_decoder (OUT_REG=1), with hand sequences for reset/hold corners.
module tb_alu_ctrl_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       opb5;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [1:0] ALUOp;
    logic [2:0] ALUControl;
    logic       out_valid;
    logic       illegal;
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    logic [7:0] illegal_cnt;
    logic       illegal_sticky;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_ctrl_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .opb5       (opb5),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUOp      (ALUOp),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        .illegal_cnt    (illegal_cnt),
        .illegal_sticky (illegal_sticky),
`endif
        .illegal    (illegal)
    );

    typedef struct {
        logic       rst;
        logic       iv;
        logic [1:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       ob5;
        logic [2:0] e_ctrl;
        logic       e_v;
        logic       e_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic iv, input logic [1:0] op,
                       input logic [2:0] f3, input logic f7, input logic ob5,
                       input logic [2:0] e_ctrl, input logic e_v, input logic e_ill);
        vec_t v;
        v.rst = rst; v.iv = iv; v.op = op; v.f3 = f3; v.f7 = f7; v.ob5 = ob5;
        v.e_ctrl = e_ctrl; v.e_v = e_v; v.e_ill = e_ill;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [1:0] op,
                         input logic [2:0] f3, input logic f7, input logic ob5);
        reset = rst; in_valid = iv; ALUOp = op; funct3 = f3; funct7b5 = f7; opb5 = ob5;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [2:0] e_ctrl,
                             input logic e_v, input logic e_ill);
        check({name, ".ctrl"}, 8'(ALUControl), 8'(e_ctrl));
        check({name, ".valid"}, 8'(out_valid), 8'(e_v));
        check({name, ".illegal"}, 8'(illegal), 8'(e_ill));
    endtask

    initial begin
        // rst iv op     f3      f7    ob5   ctrl    v     ill
        add(1, 0, 2'b00, 3'b000, 0, 0, 3'b000, 0, 0);   // reset cycle 1
        add(1, 0, 2'b00, 3'b000, 0, 0, 3'b000, 0, 0);   // reset cycle 2
        add(0, 0, 2'b00, 3'b000, 0, 0, 3'b000, 0, 0);   // released, idle
        add(0, 1, 2'b00, 3'b000, 0, 1, 3'b000, 1, 0);   // load/store
        add(0, 1, 2'b00, 3'b000, 1, 1, 3'b000, 1, 0);
        add(0, 1, 2'b01, 3'b000, 0, 1, 3'b001, 1, 0);   // branch
        add(0, 1, 2'b01, 3'b000, 1, 1, 3'b001, 1, 0);
        add(0, 1, 2'b00, 3'b101, 1, 1, 3'b000, 1, 0);   // sra fields ignored for mem
        add(0, 1, 2'b10, 3'b000, 0, 1, 3'b000, 1, 0);   // add
        add(0, 1, 2'b11, 3'b000, 1, 1, 3'b001, 1, 0);   // sub
        add(0, 1, 2'b10, 3'b000, 1, 0, 3'b000, 1, 0);   // addi with bit 30 set
        add(0, 1, 2'b10, 3'b010, 0, 1, 3'b101, 1, 0);   // slt
        add(0, 1, 2'b11, 3'b110, 0, 1, 3'b011, 1, 0);   // or
        add(0, 1, 2'b10, 3'b111, 0, 1, 3'b010, 1, 0);   // and
        add(0, 1, 2'b11, 3'b100, 0, 1, 3'b100, 1, 0);   // xor
        add(0, 1, 2'b10, 3'b001, 0, 1, 3'b110, 1, 0);   // sll
        add(0, 1, 2'b11, 3'b101, 0, 1, 3'b111, 1, 0);   // srl
        add(0, 1, 2'b10, 3'b101, 1, 1, 3'b000, 1, 1);   // sra -> illegal
        add(0, 0, 2'b10, 3'b010, 0, 1, 3'b000, 0, 1);   // idle holds illegal state

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].ob5);
            check_out($sformatf("vec%0d", i), vecs[i].e_ctrl, vecs[i].e_v, vecs[i].e_ill);
        end

        // sltu with unknown opb5/funct7b5: illegal, no X on outputs
        reset = 1'b0; in_valid = 1'b1; ALUOp = 2'b11; funct3 = 3'b011;
        opb5 = 1'bx; funct7b5 = 1'bx;
        @(posedge clk);
        #1;
        check_out("sltu_x", 3'b000, 1'b1, 1'b1);
        check("sltu_x.noX", 8'($isunknown({ALUControl, out_valid, illegal})), 8'd0);
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        check("cnt_after_illegal", illegal_cnt, 8'd2);
        check("sticky_after_illegal", 8'(illegal_sticky), 8'd1);
`endif

        // Reset beats a simultaneous legal decode
        drive(0, 1, 2'b10, 3'b001, 0, 1);
        check_out("pre_rst_sll", 3'b110, 1'b1, 1'b0);
        drive(1, 1, 2'b10, 3'b010, 0, 1);
        check_out("rst_wins", 3'b000, 1'b0, 1'b0);
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        check("cnt_cleared", illegal_cnt, 8'd0);
        check("sticky_cleared", 8'(illegal_sticky), 8'd0);
`endif

        // slt decode then three idle cycles with changing fields: output held
        drive(0, 1, 2'b10, 3'b010, 0, 1);
        check_out("slt_load", 3'b101, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 2'b10, 3'b001 + 3'(k), 1, 1);
            check_out($sformatf("slt_hold%0d", k), 3'b101, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_ctrl_decoder.md
Name: alu_ctrl_decoder

Overview:
- ALU control decoder for the single-cycle RISC-V core.
- Maps the main decoder's ALUOp plus instruction fields (funct3, funct7 bit 5, opcode bit 5) to a 3-bit ALUControl code.
- Output is registered: one pipeline stage, with a valid flag and an illegal-combination flag.
- Sits between the main control decoder and the ALU.

Parameters:
- ALUCTRL_W, 3, ALUControl width; fixed, other values unsupported.
- OUT_REG, 1: 1 = registered outputs, 1-cycle latency; 0 = combinational outputs, reset affects only the optional counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction fields valid this cycle
- opb5  in  1  opcode bit 5 (1 = R-type, 0 = I-type)
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- ALUOp  in  2  from main decoder: 00 load/store, 01 branch, 1x arithmetic/logic
- ALUControl  out  3  ALU operation code
- out_valid  out  1  registered in_valid
- illegal  out  1  decoded combination unsupported; qualified by out_valid

Behaviour:
ALUControl codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.

Decode rules:
- ALUOp=00 -> 000, regardless of other fields.
- ALUOp=01 -> 001, regardless of other fields.
- ALUOp=10 and ALUOp=11 decode identically, on funct3:
  - 000: {opb5,funct7b5}==11 -> 001 (sub); otherwise 000 (add/addi).
  - 010 -> 101.
  - 110 -> 011.
  - 111 -> 010.
  - 100 -> 100.
  - 001 -> 110.
  - 101: funct7b5=0 -> 111; funct7b5=1 (sra/srai) -> illegal, regardless of opb5.
  - 011 (sltu) -> illegal.
- On illegal: ALUControl=000 and illegal=1. Never drive X.
- Any X/Z on an input decodes as illegal in simulation (default branch). Synthesis treats don't-care as illegal.

Timing (OUT_REG=1):
- All outputs update on the rising clk edge following the inputs.
- in_valid=0: ALUControl and illegal hold their previous values; out_valid<=0.
- reset=1 at an edge: ALUControl<=000, illegal<=0, out_valid<=0. Reset wins over any simultaneous in_valid.
- Reset mid-stream discards the in-flight decode.

Timing (OUT_REG=0):
- Outputs follow the inputs combinationally; out_valid=in_valid.

Optional Feature:
Macro ALU_DEC_ILLEGAL_CNT_EN.
- Defined:
  - Adds output illegal_cnt [7:0]: saturating count of cycles where in_valid=1 and the decode is illegal; holds at 255.
  - Adds output illegal_sticky: set on the first illegal decode, held until reset.
  - Both are cleared synchronously by reset; this applies even when OUT_REG=0.
- Undefined: ports and logic are absent; the core behaviour above is unchanged.

Decomposition:
- Package alu_dec_pkg holds:
  - ALUOp encodings: ALUOP_MEM=00, ALUOP_BR=01, ALUOP_ARITH=1x.
  - The eight ALUControl localparams: ALU_ADD … ALU_SRL.
  - funct3 constants: F3_ADD, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SR, F3_OR, F3_AND.
- Sub-module alu_dec_comb: pure combinational decode from (ALUOp, funct3, funct7b5, opb5) to (ALUControl, illegal). The top adds the register stage and the optional counter.

Test Plan:
1. Reset held 2 cycles, then released with in_valid=0 -> ALUControl=000, illegal=0, out_valid=0.
2. ALUOp=00 with funct7b5=0 and then 1 (opb5=1, funct3=000) -> 000; ALUOp=01 with funct7b5=0 and then 1 -> 001; each one cycle after in_valid, out_valid=1.
3. ALUOp=10, opb5=1, funct7b5=0, funct3=000 -> 000. ALUOp=11, opb5=1, funct7b5=1, funct3=000 -> 001. opb5=0, funct7b5=1, funct3=000 (addi) -> 000.
4. ALUOp=1x sweep:
   - funct3=010 -> 101
   - funct3=110 -> 011
   - funct3=111 -> 010
   - funct3=100 -> 100
   - funct3=001 -> 110
   - funct3=101 with funct7b5=0 -> 111
   - illegal=0 for all of the above.
5. Illegal cases: ALUOp=10, opb5=1, funct7b5=1, funct3=101 -> ALUControl=000, illegal=1. ALUOp=11, funct3=011 with X on opb5/funct7b5 -> illegal=1 and no X on any output. With ALU_DEC_ILLEGAL_CNT_EN: illegal_cnt=2, illegal_sticky=1.
6. Assert reset in the same cycle as in_valid=1 with a legal op -> next cycle out_valid=0, ALUControl=000. Also: in_valid=0 for 3 cycles after a decode of 101 -> ALUControl holds 101.
